// File: rtl/dma_axi_r_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dma_axi_r_stream                                               |
// | Purpose : Multi-burst AXI4 read DMA. One start command fetches           |
// |           xfer_beats_i beats from memory as INCR bursts. Each burst is   |
// |           bounded by MAX_BURST, the 4KB page and the free space in the   |
// |           on-chip FIFO. The fetched beats leave as a valid/ready stream. |
// |           Bad RRESP and misplaced RLAST are flagged on a sticky error.   |
// | Ports   : clk, rst_n (async active-low)                                  |
// |           start_i/start_addr_i/xfer_beats_i  command                     |
// |           busy_o/done_o/error_o              status                      |
// |           m_axi_ar*                          AXI read address channel    |
// |           m_axi_r*                           AXI read data channel       |
// |           out_data_o/out_valid_o/out_last_o/out_ready_i  output stream   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dma_axi_r_stream #(
   parameter int DMA_DATA_W   = 32,
   parameter int ADDR_W       = 32,
   parameter int XFER_W       = 16,
   parameter int MAX_BURST    = 16,
   parameter int FIFO_DEPTH_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     start_addr_i,
   input  logic [XFER_W-1:0]     xfer_beats_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [3:0]            m_axi_arid_o,
   output logic [ADDR_W-1:0]     m_axi_araddr_o,
   output logic [7:0]            m_axi_arlen_o,
   output logic [2:0]            m_axi_arsize_o,
   output logic [1:0]            m_axi_arburst_o,
   output logic                  m_axi_arlock_o,
   output logic [3:0]            m_axi_arcache_o,
   output logic [2:0]            m_axi_arprot_o,
   output logic [3:0]            m_axi_arqos_o,
   output logic                  m_axi_arvalid_o,
   input  logic                  m_axi_arready_i,
   input  logic [DMA_DATA_W-1:0] m_axi_rdata_i,
   input  logic [1:0]            m_axi_rresp_i,
   input  logic                  m_axi_rlast_i,
   input  logic                  m_axi_rvalid_i,
   output logic                  m_axi_rready_o,
   output logic [DMA_DATA_W-1:0] out_data_o,
   output logic                  out_valid_o,
   output logic                  out_last_o,
   input  logic                  out_ready_i
);

   localparam int BYTES      = DMA_DATA_W / 8;
   localparam int SIZE       = $clog2(BYTES);
   localparam int DEPTH      = 2 ** FIFO_DEPTH_W;
   localparam int LEN_W      = 9;                     // burst length 1..256
   localparam int PG_W       = 13;                    // beats to page end 1..4096
   localparam int CMP_W      = (XFER_W > PG_W) ? XFER_W : PG_W;
   localparam int CNT_W      = FIFO_DEPTH_W + 1;
   localparam int FREE_CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_AR    = 2'd1,
      S_DATA  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XFER_W-1:0]   rem_q, rem_d;
   logic [XFER_W-1:0]   xfer_q, xfer_d;
   logic [XFER_W-1:0]   pop_cnt_q, pop_cnt_d;
   logic [LEN_W-1:0]    blen_q, blen_d;
   logic [LEN_W-1:0]    beat_q, beat_d;
   logic                error_q, error_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [DMA_DATA_W-1:0] mem_q [DEPTH];

   logic [CNT_W-1:0]    w_fifo_cnt;
   logic [CNT_W-1:0]    w_fifo_free;
   logic [PG_W-1:0]     w_page_beats;
   logic [CMP_W-1:0]    w_blen_ext;
   logic [LEN_W-1:0]    w_burst_len;
   logic                w_space_ok;
   logic                w_push;
   logic                w_pop;
   logic                w_last_beat;

   // ---------------------------------------------------------------------
   // FIFO occupancy; the extra pointer bit separates full from empty.
   // ---------------------------------------------------------------------
   assign w_fifo_cnt  = wr_ptr_q - rd_ptr_q;
   assign w_fifo_free = CNT_W'(DEPTH) - w_fifo_cnt;

   // ---------------------------------------------------------------------
   // Next burst length: min(remaining, MAX_BURST, beats left in 4KB page)
   // ---------------------------------------------------------------------
   assign w_page_beats = (PG_W'(4096) - {1'b0, addr_q[11:0]}) >> SIZE;

   always_comb begin
      w_blen_ext = CMP_W'(MAX_BURST);
      if (CMP_W'(rem_q) < w_blen_ext) begin
         w_blen_ext = CMP_W'(rem_q);
      end
      if (CMP_W'(w_page_beats) < w_blen_ext) begin
         w_blen_ext = CMP_W'(w_page_beats);
      end
   end

   assign w_burst_len = w_blen_ext[LEN_W-1:0];
   // The whole burst must fit before it is requested, so rready can stay
   // high through DATA without ever looking at the FIFO level.
   assign w_space_ok  = FREE_CMP_W'(w_fifo_free) >= FREE_CMP_W'(w_burst_len);

   assign w_push      = m_axi_rready_o && m_axi_rvalid_i;
   assign w_pop       = out_valid_o && out_ready_i;
   assign w_last_beat = (beat_q == (blen_q - 1'b1));

   // ---------------------------------------------------------------------
   // AXI read address / data channel outputs
   // ---------------------------------------------------------------------
   assign m_axi_arid_o    = 4'd0;
   assign m_axi_araddr_o  = addr_q;
   assign m_axi_arlen_o   = 8'(w_burst_len - 1'b1);
   assign m_axi_arsize_o  = 3'(SIZE);
   assign m_axi_arburst_o = 2'b01;
   assign m_axi_arlock_o  = 1'b0;
   assign m_axi_arcache_o = 4'b0010;
   assign m_axi_arprot_o  = 3'b010;
   assign m_axi_arqos_o   = 4'd0;
   // addr_q/rem_q are frozen in S_AR and the free space can only grow
   // there, so araddr/arlen/arvalid stay stable until arready.
   assign m_axi_arvalid_o = (state_q == S_AR) && w_space_ok;
   assign m_axi_rready_o  = (state_q == S_DATA);

   // ---------------------------------------------------------------------
   // Stream outputs; out_last is found by counting pops against the total.
   // ---------------------------------------------------------------------
   assign out_valid_o = (w_fifo_cnt != '0);
   assign out_data_o  = mem_q[rd_ptr_q[FIFO_DEPTH_W-1:0]];
   assign out_last_o  = out_valid_o && (pop_cnt_q == (xfer_q - 1'b1));

   assign busy_o  = (state_q != S_IDLE);
   assign done_o  = done_q;
   assign error_o = error_q;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      xfer_d    = xfer_q;
      blen_d    = blen_q;
      beat_d    = beat_q;
      error_d   = error_q;
      done_d    = 1'b0;
      pop_cnt_d = w_pop ? (pop_cnt_q + 1'b1) : pop_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               addr_d    = start_addr_i & ALIGN_MASK;
               rem_d     = xfer_beats_i;
               xfer_d    = xfer_beats_i;
               error_d   = 1'b0;
               pop_cnt_d = '0;
               beat_d    = '0;
               if (xfer_beats_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_AR;
               end
            end
         end

         S_AR: begin
            if (m_axi_arvalid_o && m_axi_arready_i) begin
               blen_d  = w_burst_len;
               beat_d  = '0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            if (m_axi_rvalid_i) begin
               if (m_axi_rresp_i != 2'b00) begin
                  error_d = 1'b1;
               end
               // Burst end is decided by our own beat count; a wrong
               // RLAST is only reported, never used to cut the burst.
               if (m_axi_rlast_i != w_last_beat) begin
                  error_d = 1'b1;
               end
               if (w_last_beat) begin
                  beat_d  = '0;
                  addr_d  = addr_q + (ADDR_W'(blen_q) << SIZE);
                  rem_d   = rem_q - XFER_W'(blen_q);
                  state_d = (rem_q == XFER_W'(blen_q)) ? S_DRAIN : S_AR;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end

         S_DRAIN: begin
            if (w_fifo_cnt == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State and pointer registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         xfer_q    <= '0;
         pop_cnt_q <= '0;
         blen_q    <= '0;
         beat_q    <= '0;
         error_q   <= 1'b0;
         done_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         xfer_q    <= xfer_d;
         pop_cnt_q <= pop_cnt_d;
         blen_q    <= blen_d;
         beat_q    <= beat_d;
         error_q   <= error_d;
         done_q    <= done_d;
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // FIFO storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q[FIFO_DEPTH_W-1:0]] <= m_axi_rdata_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dma_axi_r_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dma_axi_r_stream                                            |
// | Purpose : Self-checking bench for dma_axi_r_stream. An AXI read slave    |
// |           returns a hashed memory image; bursts, data and status are    |
// |           compared with a transfer-level reference model.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dma_axi_r_stream;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int XW    = 16;
   localparam int MB    = 16;
   localparam int FDW   = 5;
   localparam int DEPTH = 2 ** FDW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [XW-1:0] xfer_beats;
   logic          busy, done, error;
   logic [3:0]    arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arlock;
   logic [3:0]    arcache;
   logic [2:0]    arprot;
   logic [3:0]    arqos;
   logic          arvalid, arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast, rvalid, rready;
   logic [DW-1:0] out_data;
   logic          out_valid, out_last, out_ready;

   always #5 clk = ~clk;

   dma_axi_r_stream #(
      .DMA_DATA_W  (DW),
      .ADDR_W      (AW),
      .XFER_W      (XW),
      .MAX_BURST   (MB),
      .FIFO_DEPTH_W(FDW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start),
      .start_addr_i   (start_addr),
      .xfer_beats_i   (xfer_beats),
      .busy_o         (busy),
      .done_o         (done),
      .error_o        (error),
      .m_axi_arid_o   (arid),
      .m_axi_araddr_o (araddr),
      .m_axi_arlen_o  (arlen),
      .m_axi_arsize_o (arsize),
      .m_axi_arburst_o(arburst),
      .m_axi_arlock_o (arlock),
      .m_axi_arcache_o(arcache),
      .m_axi_arprot_o (arprot),
      .m_axi_arqos_o  (arqos),
      .m_axi_arvalid_o(arvalid),
      .m_axi_arready_i(arready),
      .m_axi_rdata_i  (rdata),
      .m_axi_rresp_i  (rresp),
      .m_axi_rlast_i  (rlast),
      .m_axi_rvalid_i (rvalid),
      .m_axi_rready_o (rready),
      .out_data_o     (out_data),
      .out_valid_o    (out_valid),
      .out_last_o     (out_last),
      .out_ready_i    (out_ready)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Slave / sink behaviour knobs (percent chance per cycle)
   int ar_pct     = 100;
   int rv_pct     = 100;
   int or_pct     = 100;
   int fault_mode = 0;   // 0 clean, 1 rresp=2 on beat 3, 2 rlast on beat 5

   logic [31:0] obs_ar_addr[$];
   int          obs_ar_len[$];
   logic [31:0] pend_addr[$];
   int          pend_len[$];
   logic [31:0] got_data[$];
   logic        got_last[$];
   int          rx_beats    = 0;
   int          popped      = 0;
   int          popped_c    = 0;
   int          done_cnt    = 0;
   int          pop_at_done = -1;
   int          s_idx       = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic pct(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // AXI read slave: records AR requests, returns beats from mem_word().
   // Handshakes are observed on the falling edge, drives change after rise.
   // ---------------------------------------------------------------------
   initial begin : slave
      logic r_fired;
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      forever begin
         @(negedge clk);
         r_fired = 1'b0;
         if (!rst_n) begin
            pend_addr.delete();
            pend_len.delete();
            s_idx = 0;
         end else begin
            if (arvalid && arready) begin
               chk("ar_fifo_space", 64'((rx_beats - popped_c + int'(arlen) + 1) <= DEPTH), 64'd1);
               chk("ar_attr", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                   {4'd0, 3'd2, 2'b01, 1'b0, 4'd2, 3'b010, 4'd0});
               obs_ar_addr.push_back(araddr);
               obs_ar_len.push_back(int'(arlen));
               pend_addr.push_back(araddr);
               pend_len.push_back(int'(arlen) + 1);
            end
            if (rvalid && rready) begin
               r_fired = 1'b1;
               rx_beats++;
               s_idx++;
               if (pend_len.size() > 0 && s_idx == pend_len[0]) begin
                  void'(pend_addr.pop_front());
                  void'(pend_len.pop_front());
                  s_idx = 0;
               end
            end
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            rresp   = 2'b00;
         end else begin
            arready = pct(ar_pct);
            if (!rvalid || r_fired) begin
               if (pend_len.size() > 0 && pct(rv_pct)) begin
                  rvalid = 1'b1;
                  rdata  = mem_word(pend_addr[0] + 32'(s_idx * 4));
                  rlast  = (s_idx == pend_len[0] - 1) || (fault_mode == 2 && rx_beats == 4);
                  rresp  = (fault_mode == 1 && rx_beats == 2) ? 2'b10 : 2'b00;
               end else begin
                  rvalid = 1'b0;
                  rlast  = 1'b0;
                  rresp  = 2'b00;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stream sink: collects popped beats and counts done pulses.
   // ---------------------------------------------------------------------
   initial begin : sink
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            popped++;
         end
         if (done) begin
            done_cnt++;
            pop_at_done = popped;
         end
         @(posedge clk);
         #1;
         popped_c  = popped;
         out_ready = pct(or_pct);
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      obs_ar_addr.delete();
      obs_ar_len.delete();
      got_data.delete();
      got_last.delete();
      rx_beats    = 0;
      popped      = 0;
      popped_c    = 0;
      done_cnt    = 0;
      pop_at_done = -1;
   endtask

   // One complete transfer checked against the reference burst plan.
   task automatic run_xfer(input string tag, input logic [31:0] addr, input int beats,
                           input logic exp_err, input int hold, input int hold_ars,
                           input logic poke);
      logic [31:0] a;
      logic [31:0] ea[$];
      int          el[$];
      int          rem, blen, page, cyc, n;
      a   = addr & ~32'h3;
      rem = beats;
      while (rem > 0) begin
         page = (4096 - int'(a[11:0])) / 4;
         blen = rem;
         if (blen > MB)   blen = MB;
         if (page < blen) blen = page;
         ea.push_back(a);
         el.push_back(blen);
         a   = a + 32'(blen * 4);
         rem = rem - blen;
      end
      clear_obs();
      if (hold > 0) or_pct = 0;
      start_addr = addr;
      xfer_beats = XW'(beats);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (poke) begin
         repeat (5) @(posedge clk);
         #1;
         start_addr = 32'h0000_8000;
         xfer_beats = XW'(3);
         start      = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         chk({tag, ":hold_ar_count"}, 64'(obs_ar_addr.size()), 64'(hold_ars));
         chk({tag, ":hold_busy"}, 64'(busy), 64'd1);
         chk({tag, ":hold_no_out"}, 64'(got_data.size()), 64'd0);
         or_pct = 100;
      end
      cyc = 0;
      while (done_cnt == 0 && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, ":done_seen"}, 64'(done_cnt != 0), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ":done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, ":pops_at_done"}, 64'(pop_at_done), 64'(beats));
      chk({tag, ":busy_after"}, 64'(busy), 64'd0);
      chk({tag, ":error"}, 64'(error), 64'(exp_err));
      chk({tag, ":ar_count"}, 64'(obs_ar_addr.size()), 64'(ea.size()));
      n = (obs_ar_addr.size() < ea.size()) ? obs_ar_addr.size() : ea.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, $sformatf(":araddr[%0d]", i)}, 64'(obs_ar_addr[i]), 64'(ea[i]));
         chk({tag, $sformatf(":arlen[%0d]", i)}, 64'(obs_ar_len[i]), 64'(el[i] - 1));
      end
      chk({tag, ":beat_count"}, 64'(got_data.size()), 64'(beats));
      n = (got_data.size() < beats) ? got_data.size() : beats;
      for (int k = 0; k < n; k++) begin
         chk({tag, $sformatf(":data[%0d]", k)}, 64'(got_data[k]),
             64'(mem_word((addr & ~32'h3) + 32'(k * 4))));
         chk({tag, $sformatf(":last[%0d]", k)}, 64'(got_last[k]), 64'(k == beats - 1));
      end
   endtask

   initial begin : main
      int cyc;
      logic [31:0] ra;
      rst_n      = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      xfer_beats = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst:busy", 64'(busy), 64'd0);
      chk("rst:done", 64'(done), 64'd0);
      chk("rst:error", 64'(error), 64'd0);
      chk("rst:arvalid", 64'(arvalid), 64'd0);
      chk("rst:rready", 64'(rready), 64'd0);
      chk("rst:out_valid", 64'(out_valid), 64'd0);
      chk("rst:out_last", 64'(out_last), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Directed: single burst, multi burst with ignored start, 4KB split
      run_xfer("single8", 32'h0000_1000, 8, 1'b0, 0, 0, 1'b0);
      run_xfer("multi40", 32'h0000_2000, 40, 1'b0, 0, 0, 1'b1);
      run_xfer("page4k", 32'h0000_0FF8, 4, 1'b0, 0, 0, 1'b0);

      // Back-pressure: FIFO of 32 takes two 16-beat bursts, third must wait
      run_xfer("bp64", 32'h0000_6000, 64, 1'b0, 100, 2, 1'b0);

      // Error reporting, sticky until the next start clears it
      fault_mode = 1;
      run_xfer("rresp_err", 32'h0000_5000, 8, 1'b1, 0, 0, 1'b0);
      fault_mode = 0;
      run_xfer("err_clear", 32'h0000_5100, 8, 1'b0, 0, 0, 1'b0);
      fault_mode = 2;
      run_xfer("rlast_early", 32'h0000_5200, 8, 1'b1, 0, 0, 1'b0);
      fault_mode = 0;

      // Reset in the middle of a data phase
      clear_obs();
      start_addr = 32'h0000_3000;
      xfer_beats = XW'(32);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 0;
      while (rx_beats < 5 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("midrst:beats_seen", 64'(rx_beats >= 5), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst:busy", 64'(busy), 64'd0);
      chk("midrst:done", 64'(done), 64'd0);
      chk("midrst:error", 64'(error), 64'd0);
      chk("midrst:arvalid", 64'(arvalid), 64'd0);
      chk("midrst:rready", 64'(rready), 64'd0);
      chk("midrst:out_valid", 64'(out_valid), 64'd0);
      chk("midrst:out_last", 64'(out_last), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Zero-beat transfer: done pulse on the next cycle, nothing else
      clear_obs();
      start_addr = 32'h0000_7000;
      xfer_beats = '0;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("zero:done", 64'(done), 64'd1);
      chk("zero:busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      chk("zero:done_gone", 64'(done), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("zero:no_ar", 64'(obs_ar_addr.size()), 64'd0);
      chk("zero:no_beats", 64'(got_data.size()), 64'd0);

      // Randomized transfers with random handshake timing
      for (int t = 0; t < 8; t++) begin
         ar_pct = int'($urandom_range(30, 100));
         rv_pct = int'($urandom_range(30, 100));
         or_pct = int'($urandom_range(30, 100));
         ra     = {12'h001, 8'($urandom_range(0, 255)), 12'h000};
         if (t % 2 == 1) begin
            ra = ra + 32'(4096 - 4 * int'($urandom_range(1, 24)));
         end else begin
            ra = ra + 32'(4 * int'($urandom_range(0, 1023)));
         end
         ra = ra | 32'($urandom_range(0, 3));
         run_xfer($sformatf("rand%0d", t), ra, int'($urandom_range(1, 70)), 1'b0, 0, 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
